udrv_stim_gen: RTL and testbench
================================

# udrv_stim_gen

Upstream stimulus generator feeding the `udrvn`/`udrvnd` inputs of the simulation top in the Verilator BFM example.
- Emits a programmable number of bursts of 32-bit LFSR-generated words with an input-controlled stall and a fixed inter-burst gap.
- Reports completion and a running XOR checksum so the SystemC harness can cross-check what the top consumed.

## Interface
- `NUM_BURSTS`, default 4: bursts per run; must be ≥1.
- `BURST_LEN`, default 8: words per burst; must be ≥1.
- `GAP_LEN`, default 2: idle cycles between bursts; 0 allowed.
- `SEED`, default 32'h0000_0001: LFSR load value at run start; zero is an elaboration error.
- `clk` in 1: sole clock; all logic on posedge.
- `reset_l` in 1: asynchronous, active-low reset.
- `start` in 1: run request; sampled only in IDLE or DONE.
- `hold` in 1: stall; while high in BURST, no word is emitted and nothing advances.
- `udrvn` out 1: word strobe; high for exactly one cycle per emitted word.
- `udrvnd` out 32: emitted word; valid when `udrvn`=1, holds last value otherwise.
- `busy` out 1: high in BURST or GAP.
- `done` out 1: sticky run-complete flag.
- `checksum` out 32: XOR of all words emitted since last accepted `start`.

## Operation
- States: IDLE, BURST, GAP, DONE.
- All outputs are registered.
- Reset values: state=IDLE; `udrvn`=0, `udrvnd`=0, `busy`=0, `done`=0, `checksum`=0; LFSR=SEED; beat and burst counters=0.
- IDLE/DONE with `start`=1:
  - go to BURST; LFSR←SEED; checksum←0; counters←0; `done`←0.
- BURST, `hold`=0, each cycle:
  - `udrvn`←1; `udrvnd`←LFSR; checksum←checksum^LFSR; LFSR←next(LFSR); beat++.
- BURST, `hold`=1:
  - `udrvn`←0; LFSR, counters and checksum unchanged.
- Last beat of a burst (beat==BURST_LEN-1, emitted):
  - beat←0; burst++.
  - Then: DONE if that was burst NUM_BURSTS-1; else GAP if GAP_LEN>0; else directly BURST, so the strobe stays continuous.
- GAP:
  - `udrvn`=0; counts GAP_LEN cycles, then BURST.
  - `hold` is ignored during GAP.
- DONE:
  - `done`=1 and `busy`=0 until the next accepted `start`.
- LFSR: 32-bit Galois, right shift, polynomial x^32+x^22+x^2+x+1.
  - next(x) = (x>>1) ^ (x[0] ? 32'h8020_0003 : 0).
- `start` while busy is ignored; it neither restarts nor queues.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit.

## Timing
- `start` high in cycle 0 (sampled at edge 1): `busy` is high from cycle 1; first `udrvn`=1 in cycle 2 if `hold`=0.
- `hold` sampled at edge k: the `udrvn` visible in cycle k reflects `hold` from cycle k-1. One-cycle registered response, no combinational path from `hold` to outputs.
- Total strobes per run: exactly NUM_BURSTS×BURST_LEN, regardless of `hold` pattern.
- Minimum run length with `hold`=0:
  - NUM_BURSTS×BURST_LEN + (NUM_BURSTS-1)×GAP_LEN cycles of BURST/GAP.
  - `done` rises the cycle after the final strobe.
- `reset_l` low mid-run: all state and outputs clear immediately (asynchronous); after release, IDLE, and no strobe occurs until a new `start`.
- `start` held high continuously: a new run is accepted each time DONE is reached.
  - `done` is high for exactly one cycle between runs.

## Structure
- Package `udrv_pkg`:
  - state enum `udrv_state_t`;
  - `LFSR_POLY`=32'h8020_0003;
  - function `lfsr_next`.
- Sub-module `udrv_lfsr32`: the LFSR register with load and enable, plus the SEED≠0 elaboration check.
- Everything else lives in `udrv_stim_gen`: FSM, counters, output registers, checksum.

## Test plan
- SEED=1, NUM_BURSTS=1, BURST_LEN=4, `hold`=0, pulse `start`:
  - words 0x00000001, 0x80200003, 0xC0300002, 0x60180001 in cycles 2–5;
  - `done`=1 in cycle 6; checksum=0x20080001.
- Same config, `hold`=1 during cycles 2–3:
  - identical word sequence, delayed 2 cycles;
  - checksum unchanged; still exactly 4 strobes.
- NUM_BURSTS=3, BURST_LEN=2, GAP_LEN=2:
  - strobe pattern 11 00 11 00 11;
  - `busy` high for 10 cycles; 6 strobes total.
- GAP_LEN=0, NUM_BURSTS=2, BURST_LEN=3:
  - 6 consecutive strobes with no bubble.
- `reset_l` pulsed low after the second strobe:
  - all outputs 0 asynchronously; no strobes after release without `start`;
  - a new `start` reproduces the sequence from 0x00000001.
- `start` pulsed mid-run:
  - ignored; word count and checksum match the undisturbed run;
  - `start` in DONE clears `done` and checksum, and reruns.

Source files
------------

// File: rtl/udrv_pkg.sv
// Shared types and LFSR helpers for the udrv stimulus generator.
package udrv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_GAP,
    ST_DONE
  } udrv_state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Galois right-shift step for x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/udrv_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and advance enable.
module udrv_lfsr32
  import udrv_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        load,
  input  logic        en,
  output logic [31:0] q
);

  // An all-zero state is a fixed point of the LFSR.
  if (SEED == '0) begin : g_seed_check
    $error("udrv_lfsr32: SEED must be nonzero");
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      q <= SEED;
    end else if (load) begin
      q <= SEED;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/udrv_stim_gen.sv
// Burst stimulus generator: LFSR words in bursts with stall, gaps, checksum.
module udrv_stim_gen #(
  parameter int unsigned NUM_BURSTS = 4,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned GAP_LEN    = 2,
  parameter logic [31:0] SEED       = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        start,
  input  logic        hold,
  output logic        udrvn,
  output logic [31:0] udrvnd,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);
  import udrv_pkg::*;

  if (NUM_BURSTS < 1) begin : g_nb_check
    $error("udrv_stim_gen: NUM_BURSTS must be >= 1");
  end
  if (BURST_LEN < 1) begin : g_bl_check
    $error("udrv_stim_gen: BURST_LEN must be >= 1");
  end

  localparam int unsigned BEAT_W  = (BURST_LEN  > 1) ? $clog2(BURST_LEN)  : 1;
  localparam int unsigned BURST_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int unsigned GAP_W   = (GAP_LEN    > 1) ? $clog2(GAP_LEN)    : 1;

  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(NUM_BURSTS - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  udrv_state_t        state;
  logic [BEAT_W-1:0]  beat;
  logic [BURST_W-1:0] burst;
  logic [GAP_W-1:0]   gap;
  logic [31:0]        lfsr_q;
  logic               accept;
  logic               lfsr_en;

  // DONE accepts a new run only once done has been shown for a cycle, so
  // a continuously held start still yields a one-cycle done pulse.
  always_comb begin
    accept  = start && ((state == ST_IDLE) || (state == ST_DONE && done));
    lfsr_en = (state == ST_BURST) && !hold;
  end

  udrv_lfsr32 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset_l(reset_l),
    .load   (accept),
    .en     (lfsr_en),
    .q      (lfsr_q)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state    <= ST_IDLE;
      udrvn    <= 1'b0;
      udrvnd   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      checksum <= '0;
      beat     <= '0;
      burst    <= '0;
      gap      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          udrvn <= 1'b0;
          if (accept) begin
            state    <= ST_BURST;
            busy     <= 1'b1;
            done     <= 1'b0;
            checksum <= '0;
            beat     <= '0;
            burst    <= '0;
            gap      <= '0;
          end else if (state == ST_DONE) begin
            done <= 1'b1;
          end
        end

        ST_BURST: begin
          udrvn <= !hold;
          if (!hold) begin
            udrvnd   <= lfsr_q;
            checksum <= checksum ^ lfsr_q;
            if (beat == BEAT_LAST) begin
              beat  <= '0;
              burst <= burst + 1'b1;
              if (burst == BURST_LAST) begin
                state <= ST_DONE;
                busy  <= 1'b0;
              end else if (GAP_LEN != 0) begin
                state <= ST_GAP;
                gap   <= '0;
              end
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end

        ST_GAP: begin
          udrvn <= 1'b0;
          if (gap == GAP_LAST) begin
            state <= ST_BURST;
          end else begin
            gap <= gap + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udrv_stim_gen.sv
// Scoreboard bench for udrv_stim_gen across three burst/gap configurations.
module tb_udrv_stim_gen;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        start;
  logic        hold;

  logic        udrvn_a, busy_a, done_a;
  logic [31:0] udrvnd_a, checksum_a;
  logic        udrvn_b, busy_b, done_b;
  logic [31:0] udrvnd_b, checksum_b;
  logic        udrvn_c, busy_c, done_c;
  logic [31:0] udrvnd_c, checksum_c;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] q_c[$];

  always #5 clk = ~clk;

  udrv_stim_gen #(.NUM_BURSTS(1), .BURST_LEN(4), .GAP_LEN(2)) u_a (
    .clk(clk), .reset_l(reset_l), .start(start), .hold(hold),
    .udrvn(udrvn_a), .udrvnd(udrvnd_a), .busy(busy_a), .done(done_a),
    .checksum(checksum_a)
  );

  udrv_stim_gen #(.NUM_BURSTS(3), .BURST_LEN(2), .GAP_LEN(2)) u_b (
    .clk(clk), .reset_l(reset_l), .start(start), .hold(hold),
    .udrvn(udrvn_b), .udrvnd(udrvnd_b), .busy(busy_b), .done(done_b),
    .checksum(checksum_b)
  );

  udrv_stim_gen #(.NUM_BURSTS(2), .BURST_LEN(3), .GAP_LEN(0)) u_c (
    .clk(clk), .reset_l(reset_l), .start(start), .hold(hold),
    .udrvn(udrvn_c), .udrvnd(udrvnd_c), .busy(busy_c), .done(done_c),
    .checksum(checksum_c)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_step(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] model_csum(input int unsigned n);
    logic [31:0] x, c;
    x = 32'h1;
    c = '0;
    for (int unsigned i = 0; i < n; i++) begin
      c = c ^ x;
      x = model_step(x);
    end
    return c;
  endfunction

  // which: 0=A (4 words/run), 1=B (6), 2=C (6)
  task automatic push_runs(input int unsigned which, input int unsigned runs);
    logic [31:0] x;
    int unsigned n;
    n = (which == 0) ? 4 : 6;
    for (int unsigned r = 0; r < runs; r++) begin
      x = 32'h1;
      for (int unsigned i = 0; i < n; i++) begin
        case (which)
          0:       q_a.push_back(x);
          1:       q_b.push_back(x);
          default: q_c.push_back(x);
        endcase
        x = model_step(x);
      end
    end
  endtask

  task automatic push_all();
    push_runs(0, 1);
    push_runs(1, 1);
    push_runs(2, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_all_done(input int unsigned max_cycles);
    int unsigned k = 0;
    while (!(done_a && done_b && done_c) && k < max_cycles) begin
      tick();
      k++;
    end
    check_val("wait_done", {29'b0, done_a, done_b, done_c}, 32'd7);
  endtask

  task automatic check_run_end(input string tag);
    check_val({tag, "_csum_a"}, checksum_a, 32'h2008_0001);
    check_val({tag, "_csum_b"}, checksum_b, model_csum(6));
    check_val({tag, "_csum_c"}, checksum_c, model_csum(6));
    check_val({tag, "_qa_empty"}, 32'(q_a.size()), 32'd0);
    check_val({tag, "_qb_empty"}, 32'(q_b.size()), 32'd0);
    check_val({tag, "_qc_empty"}, 32'(q_c.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (udrvn_a) begin
      if (q_a.size() == 0) check_val("strobe_a_pending", 32'(q_a.size()), 32'd1);
      else check_val("word_a", udrvnd_a, q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (udrvn_b) begin
      if (q_b.size() == 0) check_val("strobe_b_pending", 32'(q_b.size()), 32'd1);
      else check_val("word_b", udrvnd_b, q_b.pop_front());
    end
  end

  always @(negedge clk) begin
    if (udrvn_c) begin
      if (q_c.size() == 0) check_val("strobe_c_pending", 32'(q_c.size()), 32'd1);
      else check_val("word_c", udrvnd_c, q_c.pop_front());
    end
  end

  initial begin
    logic [15:0] sa, ba, da, sb, bb, db, sc, bc, dc;
    int unsigned done_hi, done_rise;
    logic prev_done;

    reset_l = 1'b0;
    start   = 1'b0;
    hold    = 1'b0;
    #3;
    check_val("rst_a", {udrvn_a, busy_a, done_a, 29'b0}, 32'd0);
    check_val("rst_udrvnd_a", udrvnd_a, 32'd0);
    check_val("rst_csum_a", checksum_a, 32'd0);
    tick();
    tick();
    reset_l = 1'b1;
    tick();

    // Test 1: basic run on all three configurations, cycle-accurate patterns.
    sa = '0; ba = '0; da = '0; sb = '0; bb = '0; db = '0; sc = '0; bc = '0; dc = '0;
    push_all();
    start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      sa[c] = udrvn_a; ba[c] = busy_a; da[c] = done_a;
      sb[c] = udrvn_b; bb[c] = busy_b; db[c] = done_b;
      sc[c] = udrvn_c; bc[c] = busy_c; dc[c] = done_c;
    end
    check_val("t1_strb_a", {16'b0, sa}, 32'h003C);
    check_val("t1_busy_a", {16'b0, ba}, 32'h001E);
    check_val("t1_done_a", {16'b0, da}, 32'h3FC0);
    check_val("t1_strb_b", {16'b0, sb}, 32'h0CCC);
    check_val("t1_busy_b", {16'b0, bb}, 32'h07FE);
    check_val("t1_done_b", {16'b0, db}, 32'h3000);
    check_val("t1_strb_c", {16'b0, sc}, 32'h00FC);
    check_val("t1_busy_c", {16'b0, bc}, 32'h007E);
    check_val("t1_done_c", {16'b0, dc}, 32'h3F00);
    check_run_end("t1");

    // Test 2: hold high in cycles 2-3 stalls A by two cycles.
    sa = '0; da = '0;
    push_all();
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      hold = (c == 2 || c == 3);
      sa[c] = udrvn_a; da[c] = done_a;
    end
    hold = 1'b0;
    check_val("t2_strb_a", {16'b0, sa}, 32'h00E4);
    check_val("t2_done_a", {16'b0, da}, 32'h7F00);
    wait_all_done(50);
    check_run_end("t2");

    // Test 3: asynchronous reset after A's second strobe.
    push_all();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #6;
    reset_l = 1'b0;
    #1;
    check_val("t3_rst_a", {udrvn_a, busy_a, done_a, 29'b0}, 32'd0);
    check_val("t3_rst_udrvnd_a", udrvnd_a, 32'd0);
    check_val("t3_rst_csum_a", checksum_a, 32'd0);
    check_val("t3_rst_b", {udrvn_b, busy_b, udrvn_c, busy_c, 28'b0}, 32'd0);
    q_a.delete();
    q_b.delete();
    q_c.delete();
    tick();
    tick();
    reset_l = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    check_val("t3_idle_a", {udrvn_a, busy_a, done_a, 29'b0}, 32'd0);
    push_all();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_all_done(50);
    check_run_end("t3");

    // Test 4: start mid-run is ignored; start in DONE clears and reruns.
    push_all();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_all_done(50);
    check_run_end("t4a");
    push_all();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("t4_done_clr_a", {31'b0, done_a}, 32'd0);
    check_val("t4_busy_a", {31'b0, busy_a}, 32'd1);
    check_val("t4_csum_clr_a", checksum_a, 32'd0);
    wait_all_done(50);
    check_run_end("t4b");

    // Test 5: start held high: back-to-back runs, one-cycle done pulses on A.
    push_runs(0, 4);
    push_runs(1, 2);
    push_runs(2, 3);
    done_hi = 0;
    done_rise = 0;
    prev_done = done_a;
    start = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      tick();
      if (done_a) done_hi++;
      if (done_a && !prev_done) done_rise++;
      prev_done = done_a;
    end
    start = 1'b0;
    check_val("t5_done_cycles_a", done_hi, 32'd3);
    check_val("t5_done_pulses_a", done_rise, 32'd3);
    wait_all_done(100);
    check_run_end("t5");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
